// File: rtl/radix8_booth_mul_seq.sv
// Sequential radix-8 Booth multiplier: one Booth digit per clock, exact 2*WIDTH-bit
// product, per-operation signed/unsigned mode, valid/ready handshakes on both sides.
module radix8_booth_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int NDIG = (WIDTH + 3) / 3;
  localparam int PW   = 2 * WIDTH;
  localparam int BW   = 3 * NDIG + 1;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, PREP, ACCUM, DONE} state_t;

  state_t          state_reg;
  logic [PW-1:0]   a_reg;
  logic [PW-1:0]   a3_reg;
  logic [PW-1:0]   acc_reg;
  logic [BW-1:0]   b_reg;
  logic [CW-1:0]   cnt_reg;

  logic            accept;
  logic [WIDTH:0]  a_ext;
  logic [WIDTH:0]  b_ext;
  logic [PW-1:0]   a_load;
  logic [BW-2:0]   b_wide;
  logic [WIDTH+2:0] a3_narrow;
  logic [PW-1:0]   pp_next;

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == PREP) || (state_reg == ACCUM);
  assign product   = acc_reg;

  // Operands widened by one bit so unsigned values look like non-negative signed ones.
  assign a_ext  = {signed_mode & multiplicand[WIDTH-1], multiplicand};
  assign b_ext  = {signed_mode & multiplier[WIDTH-1], multiplier};
  assign a_load = PW'($signed(a_ext));
  assign b_wide = (BW-1)'($signed(b_ext));

  // 3A fits in WIDTH+3 bits; its top bit already carries the correct extension.
  assign a3_narrow = a_reg[WIDTH+2:0] + {a_reg[WIDTH+1:0], 1'b0};

  // a_reg/a3_reg are pre-shifted by 8^i, so the window selects the aligned multiple.
  always_comb begin
    pp_next = '0;
    unique case (b_reg[3:0])
      4'b0001, 4'b0010: pp_next = a_reg;
      4'b0011, 4'b0100: pp_next = a_reg << 1;
      4'b0101, 4'b0110: pp_next = a3_reg;
      4'b0111:          pp_next = a_reg << 2;
      4'b1000:          pp_next = -(a_reg << 2);
      4'b1001, 4'b1010: pp_next = -a3_reg;
      4'b1011, 4'b1100: pp_next = -(a_reg << 1);
      4'b1101, 4'b1110: pp_next = -a_reg;
      default:          pp_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      a3_reg    <= '0;
      acc_reg   <= '0;
      b_reg     <= '0;
      cnt_reg   <= '0;
    end else if (accept) begin
      state_reg <= PREP;
      a_reg     <= a_load;
      a3_reg    <= '0;
      acc_reg   <= '0;
      b_reg     <= {b_wide, 1'b0};
      cnt_reg   <= '0;
    end else begin
      unique case (state_reg)
        IDLE: state_reg <= IDLE;
        PREP: begin
          a3_reg    <= PW'($signed(a3_narrow));
          state_reg <= ACCUM;
        end
        ACCUM: begin
          acc_reg <= acc_reg + pp_next;
          a_reg   <= a_reg << 3;
          a3_reg  <= a3_reg << 3;
          b_reg   <= {{3{b_reg[BW-1]}}, b_reg[BW-1:3]};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(NDIG - 1)) state_reg <= DONE;
        end
        DONE: if (out_ready) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
